// File: rtl/instruction_memory_if.sv
// Fetch/load bus between the pc stage, debug loader and the instruction memory.
// Signal names keep the memory-side i_/o_ view so both ends share one vocabulary.
interface instruction_memory_if #(
  parameter int BYTE_SIZE = 8,
  parameter int WORD_SIZE = 32,
  parameter int PC_SIZE   = 32
);
  logic                 i_clear;
  logic                 i_wr_en;
  logic [BYTE_SIZE-1:0] i_data;
  logic [PC_SIZE-1:0]   i_pc;
  logic [WORD_SIZE-1:0] o_instruction;
  logic                 o_full;
  logic                 o_empty;

  modport master (
    output i_clear, i_wr_en, i_data, i_pc,
    input  o_instruction, o_full, o_empty
  );

  modport slave (
    input  i_clear, i_wr_en, i_data, i_pc,
    output o_instruction, o_full, o_empty
  );
endinterface

// File: rtl/instruction_memory.sv
// Word-organised instruction store: byte-serial big-endian program load,
// combinational fetch by byte PC, fill-level flags and full program clear.
module instruction_memory #(
  parameter int WORD_SIZE         = 32,
  parameter int BYTE_SIZE         = 8,
  parameter int MEM_SIZE_IN_WORDS = 64,
  parameter int PC_SIZE           = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  instruction_memory_if.slave   bus
);

  localparam int IDX_W = $clog2(MEM_SIZE_IN_WORDS);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0]     PTR_FULL  = PTR_W'(MEM_SIZE_IN_WORDS);
  localparam logic [PC_SIZE-3:0]   IDX_LIMIT = (PC_SIZE-2)'(MEM_SIZE_IN_WORDS);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE_IN_WORDS];
  logic [1:0]           byte_cnt;
  logic [PTR_W-1:0]     word_ptr;
  logic [WORD_SIZE-1:0] asm_word;

  logic                 full;
  logic                 load_accept;
  logic [PC_SIZE-3:0]   pc_word_idx;
  logic                 unused_bits;

  assign full        = (word_ptr == PTR_FULL);
  assign load_accept = bus.i_wr_en && !full;

  // NOTE: the whole array is cleared on reset/clear because unloaded words must
  // read as NOP; this forces flops rather than a RAM macro, which is intended here.
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_clear) begin
      for (int i = 0; i < MEM_SIZE_IN_WORDS; i++) begin
        mem[i] <= '0;
      end
      byte_cnt <= '0;
      word_ptr <= '0;
      asm_word <= '0;
    end else if (load_accept) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the 4th-byte commit relies on the old asm_word.
      case (byte_cnt)
        2'd0: asm_word[WORD_SIZE-1 -: BYTE_SIZE]             <= bus.i_data;
        2'd1: asm_word[WORD_SIZE-BYTE_SIZE-1 -: BYTE_SIZE]   <= bus.i_data;
        2'd2: asm_word[WORD_SIZE-2*BYTE_SIZE-1 -: BYTE_SIZE] <= bus.i_data;
        default: begin
          asm_word[BYTE_SIZE-1:0]         <= bus.i_data;
          mem[word_ptr[IDX_W-1:0]]        <= {asm_word[WORD_SIZE-1:BYTE_SIZE], bus.i_data};
          word_ptr                        <= word_ptr + 1'b1;
        end
      endcase
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Fetch ignores the byte offset; out-of-range words return NOP instead of X.
  assign pc_word_idx = bus.i_pc[PC_SIZE-1:2];

  // NOTE: the else branch gives o_instruction a value on every path, so the
  // combinational read cannot infer a latch.
  always_comb begin
    if (pc_word_idx < IDX_LIMIT) begin
      bus.o_instruction = mem[pc_word_idx[IDX_W-1:0]];
    end else begin
      bus.o_instruction = '0;
    end
  end

  assign bus.o_full  = full;
  assign bus.o_empty = (word_ptr == '0) && (byte_cnt == 2'd0);

  // Byte offset of the PC and the low assembly byte are intentionally not read.
  assign unused_bits = ^{bus.i_pc[1:0], asm_word[BYTE_SIZE-1:0]};

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
Word-organised instruction ROM/RAM for the IF stage, directly downstream of the program counter. It consumes the PC value and returns the addressed 32-bit instruction to the IF/ID boundary. Before execution, the debug unit loads the program byte-serially over its UART path. The block assembles those bytes into words, tracks fill level, and supports a full program clear.

Parameters:
WORD_SIZE, 32, instruction width in bits (fixed to 4 bytes)
BYTE_SIZE, 8, width of one load byte
MEM_SIZE_IN_WORDS, 64, instruction capacity in words
PC_SIZE, 32, width of the byte address input

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_reset  input  1  synchronous active-high reset
i_clear  input  1  synchronous program clear, same effect as reset
i_wr_en  input  1  load strobe, one byte accepted per asserted cycle
i_data  input  BYTE_SIZE  load byte from debug unit
i_pc  input  PC_SIZE  byte address of instruction to fetch (from pc stage)
o_instruction  output  WORD_SIZE  instruction at i_pc
o_full  output  1  all MEM_SIZE_IN_WORDS words written
o_empty  output  1  no byte written since last reset/clear

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of i_clk.
- State:
  - word array mem[0..MEM_SIZE_IN_WORDS-1]
  - byte_cnt, 2 bits
  - word_ptr, $clog2(MEM_SIZE_IN_WORDS)+1 bits
  - assembly register asm_word, WORD_SIZE bits
- Reset or i_clear:
  - every mem word = 0 (NOP), byte_cnt = 0, word_ptr = 0, asm_word = 0.
  - Outputs next cycle: o_empty=1, o_full=0, o_instruction=0.
- i_clear together with i_wr_en: clear wins and the byte is dropped. Clear mid-load discards any partial word.
- Load, when i_wr_en=1 and o_full=0:
  - Bytes are big-endian: 1st byte -> bits [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
  - Bytes 1-3 go into asm_word; byte_cnt increments.
  - On the 4th byte: mem[word_ptr] <= {asm_word[31:8], i_data}, word_ptr increments, byte_cnt wraps 3->0.
  - The committed word is readable on the cycle after the 4th-byte edge.
- i_wr_en while o_full=1: byte ignored, no state change, o_full stays 1.
- o_full = (word_ptr == MEM_SIZE_IN_WORDS). A partial word is impossible while full.
- o_empty = (word_ptr == 0 && byte_cnt == 0). It deasserts the cycle after the first accepted byte.
- Fetch read is combinational (zero latency), because the pc stage already registers the address:
  - word index = i_pc[PC_SIZE-1:2]; i_pc[1:0] is ignored (misaligned PC reads the containing word).
  - Index >= MEM_SIZE_IN_WORDS returns 0 (NOP), never X.
  - Reading a word on the same cycle it is committed returns the old content.
- Unloaded addresses read 0.
- Fetching during loading is permitted; the program is not protected.

Test Plan:
- Reset: assert i_reset 2 cycles, i_pc=0 -> o_instruction=0x00000000, o_empty=1, o_full=0.
- Load bytes 0x20,0x08,0x00,0x05 on 4 consecutive cycles, then i_pc=0 -> o_instruction=0x20080005 the cycle after the 4th byte. o_empty drops after the 1st byte.
- Load 2 words (0x11223344, 0xAABBCCDD). i_pc=4 -> 0xAABBCCDD; i_pc=7 -> 0xAABBCCDD; i_pc=8 -> 0; i_pc=0x1000 -> 0.
- Load 256 bytes -> o_full=1 after the 256th byte. A 257th byte 0xFF is ignored; mem[0] unchanged.
- Load 2 bytes, pulse i_clear with i_wr_en=1, then load 0xDEADBEEF -> i_pc=0 reads 0xDEADBEEF, o_empty=1 right after the clear.
- Load 1 word, assert i_reset mid-second-word -> all reads 0, o_empty=1; a subsequent 4-byte load lands at address 0.
